// File: rtl/vector_register_file_v2.sv
// rtl/vector_register_file_v2.sv - multi-port vector register file with byte-enable writes, write-first bypass and bulk clear
module vector_register_file_v2 #(
  parameter int W  = 32,
  parameter int L  = 32,
  parameter int NR = 3,
  parameter int NW = 2,
  parameter int A  = $clog2(L),
  localparam int BE = W / 8
) (
  input  logic                    clk,
  input  logic                    n_reset,
  input  logic [NW-1:0]           wr_en,
  input  logic [NW-1:0][A-1:0]    wr_addr,
  input  logic [NW-1:0][W-1:0]    wr_data,
  input  logic [NW-1:0][BE-1:0]   wr_be,
  input  logic [NR-1:0]           rd_en,
  input  logic [NR-1:0][A-1:0]    rd_addr,
  output logic [NR-1:0][W-1:0]    rd_data,
  output logic [NR-1:0]           rd_valid,
  input  logic                    clr_req,
  output logic                    ready,
  output logic                    clr_done
);

  // Addresses are compared one bit wider so L need not be a power of two.
  localparam logic [A:0]   ADDR_LIM = (A+1)'(L);
  localparam logic [A-1:0] LAST     = A'(L - 1);

  typedef enum logic {S_IDLE, S_CLEAR} state_t;

  state_t              state;
  logic [A-1:0]        cnt;
  logic [L-1:0][W-1:0] regs;
  logic [NW-1:0]       wr_acc;
  logic [NR-1:0]       rd_hit;
  logic [NR-1:0][W-1:0] rd_next;

  // Write acceptance: port enabled, array not busy clearing, address inside the array.
  always_comb begin
    wr_acc = '0;
    for (int i = 0; i < NW; i++) begin
      wr_acc[i] = wr_en[i] & ready & ({1'b0, wr_addr[i]} < ADDR_LIM);
    end
  end

  // Read operand: stored value with this cycle's accepted writes merged per byte,
  // applied in port order so the highest-index port owns each contested byte.
  always_comb begin
    rd_hit  = '0;
    rd_next = '0;
    for (int j = 0; j < NR; j++) begin
      rd_hit[j]  = ({1'b0, rd_addr[j]} < ADDR_LIM);
      rd_next[j] = rd_hit[j] ? regs[rd_addr[j]] : '0;
      for (int i = 0; i < NW; i++) begin
        for (int b = 0; b < BE; b++) begin
          if (wr_acc[i] && (wr_addr[i] == rd_addr[j]) && wr_be[i][b]) begin
            rd_next[j][8*b +: 8] = wr_data[i][8*b +: 8];
          end
        end
      end
    end
  end

  // Clear sequencer: ready and clr_done are registered; clr_done marks the last clear cycle.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state    <= S_IDLE;
      cnt      <= '0;
      ready    <= 1'b0;
      clr_done <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (clr_req) begin
            state    <= S_CLEAR;
            cnt      <= '0;
            ready    <= 1'b0;
            clr_done <= (L == 1);
          end else begin
            ready    <= 1'b1;
            clr_done <= 1'b0;
          end
        end
        S_CLEAR: begin
          if (cnt == LAST) begin
            state    <= S_IDLE;
            ready    <= 1'b1;
            clr_done <= 1'b0;
          end else begin
            cnt      <= cnt + A'(1);
            clr_done <= ((cnt + A'(1)) == LAST);
          end
        end
        default: begin
          state    <= S_IDLE;
          ready    <= 1'b0;
          clr_done <= 1'b0;
        end
      endcase
    end
  end

  // Storage: one register zeroed per clear cycle, otherwise byte-enabled writes,
  // later ports overriding earlier ones on the same byte.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      regs <= '0;
    end else if (state == S_CLEAR) begin
      regs[cnt] <= '0;
    end else begin
      for (int r = 0; r < L; r++) begin
        for (int i = 0; i < NW; i++) begin
          for (int b = 0; b < BE; b++) begin
            if (wr_acc[i] && (wr_addr[i] == A'(r)) && wr_be[i][b]) begin
              regs[r][8*b +: 8] <= wr_data[i][8*b +: 8];
            end
          end
        end
      end
    end
  end

  // Read ports: one-cycle registered result; data holds when no read is accepted.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      rd_data  <= '0;
      rd_valid <= '0;
    end else begin
      for (int j = 0; j < NR; j++) begin
        rd_valid[j] <= rd_en[j] & ready;
        if (rd_en[j] && ready) begin
          rd_data[j] <= rd_next[j];
        end
      end
    end
  end

endmodule
